// File: rtl/dbus_sram_bridge.sv
// dbus_sram_bridge: runs 32-bit dbus requests as one or two halfword phases on a 16-bit async SRAM.
module dbus_sram_bridge #(
  parameter int ADDR_WIDTH = 20,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           dbus_address,
  input  logic [3:0]            dbus_byteenable,
  input  logic                  dbus_read,
  input  logic                  dbus_write,
  input  logic [31:0]           dbus_wrdata,
  output logic [31:0]           dbus_rddata,
  output logic                  dbus_stall,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [15:0]           sram_data_i,
  output logic [15:0]           sram_data_o,
  output logic                  sram_data_oe,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic                  sram_lb_n,
  output logic                  sram_ub_n
);
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  state_t state;
  logic wr_q;
  logic [ADDR_WIDTH-2:0] word_q;
  logic [3:0] be_q;
  logic [31:0] wd_q;
  logic [3:0] cnt;
  logic req, idle, busy, phase_end, start_lo, start_hi, to_done, wr_n;
  logic [3:0] be_n;
  logic [ADDR_WIDTH-2:0] word_n;
  logic [31:0] wd_n;
  logic unused;
  assign req = dbus_read | dbus_write;
  assign idle = state == IDLE;
  assign busy = state == LO || state == HI;
  assign dbus_stall = req && state != DONE;
  // Phase setup draws on the live request in IDLE and on the latched copy afterwards.
  assign be_n = idle ? dbus_byteenable : be_q;
  assign wr_n = idle ? dbus_write : wr_q;
  assign word_n = idle ? dbus_address[ADDR_WIDTH:2] : word_q;
  assign wd_n = idle ? dbus_wrdata : wd_q;
  assign phase_end = busy && cnt == (wr_q ? 4'(WAIT_CYCLES) : 4'(WAIT_CYCLES - 1));
  assign start_lo = idle && req && |dbus_byteenable[1:0];
  assign start_hi = (idle && req && ~|dbus_byteenable[1:0] && |dbus_byteenable[3:2]) ||
                    (state == LO && phase_end && |be_q[3:2]);
  assign to_done = (idle && req && ~|dbus_byteenable) || (phase_end && !start_hi);
  assign unused = ^{dbus_address[31:ADDR_WIDTH+1], dbus_address[1:0]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wr_q <= 1'b0;
      word_q <= '0;
      be_q <= '0;
      wd_q <= '0;
      cnt <= '0;
      dbus_rddata <= '0;
      sram_addr <= '0;
      sram_data_o <= '0;
      sram_data_oe <= 1'b0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_lb_n <= 1'b1;
      sram_ub_n <= 1'b1;
    end else begin
      state <= start_lo ? LO : start_hi ? HI : to_done ? DONE : state == DONE ? IDLE : state;
      if (idle && req) begin
        wr_q <= dbus_write;
        word_q <= dbus_address[ADDR_WIDTH:2];
        be_q <= dbus_byteenable;
        wd_q <= dbus_wrdata;
        dbus_rddata <= '0;
      end
      if (busy)
        cnt <= cnt + 4'd1;
      if (busy && !wr_q && phase_end)
        for (int i = 0; i < 4; i++)
          if (be_q[i] && ((i >= 2) == (state == HI)))
            dbus_rddata[8*i +: 8] <= sram_data_i[8*(i%2) +: 8];
      // Release the write strobe one cycle early so address/data hold through recovery.
      if (busy && wr_q && cnt == 4'(WAIT_CYCLES - 1))
        sram_we_n <= 1'b1;
      if (start_lo || start_hi) begin
        cnt <= '0;
        sram_addr <= {word_n, start_hi};
        sram_ce_n <= 1'b0;
        sram_oe_n <= wr_n;
        sram_we_n <= !wr_n;
        sram_lb_n <= !(start_hi ? be_n[2] : be_n[0]);
        sram_ub_n <= !(start_hi ? be_n[3] : be_n[1]);
        sram_data_oe <= wr_n;
        sram_data_o <= start_hi ? wd_n[31:16] : wd_n[15:0];
      end else if (to_done) begin
        sram_ce_n <= 1'b1;
        sram_oe_n <= 1'b1;
        sram_we_n <= 1'b1;
        sram_lb_n <= 1'b1;
        sram_ub_n <= 1'b1;
        sram_data_oe <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dbus_sram_bridge.sv
// tb_dbus_sram_bridge: directed vector bench; instance 0 uses WAIT_CYCLES=1, instance 1 uses WAIT_CYCLES=3.
module tb_dbus_sram_bridge;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n[2];
  logic [31:0] addr[2], wrdata[2], rddata[2];
  logic [3:0] be[2];
  logic rd[2], wr[2], stall[2];
  logic [19:0] saddr[2];
  logic [15:0] sdi[2], sdo[2];
  logic soe[2], ce_n[2], oe_n[2], we_n[2], lb_n[2], ub_n[2];
  logic [15:0] mem[2][256];
  bit written[2][256];
  int n_chk = 0;
  int n_fail = 0;

  dbus_sram_bridge #(.ADDR_WIDTH(20), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n[0]), .dbus_address(addr[0]), .dbus_byteenable(be[0]),
    .dbus_read(rd[0]), .dbus_write(wr[0]), .dbus_wrdata(wrdata[0]), .dbus_rddata(rddata[0]),
    .dbus_stall(stall[0]), .sram_addr(saddr[0]), .sram_data_i(sdi[0]), .sram_data_o(sdo[0]),
    .sram_data_oe(soe[0]), .sram_ce_n(ce_n[0]), .sram_oe_n(oe_n[0]), .sram_we_n(we_n[0]),
    .sram_lb_n(lb_n[0]), .sram_ub_n(ub_n[0]));
  dbus_sram_bridge #(.ADDR_WIDTH(20), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n[1]), .dbus_address(addr[1]), .dbus_byteenable(be[1]),
    .dbus_read(rd[1]), .dbus_write(wr[1]), .dbus_wrdata(wrdata[1]), .dbus_rddata(rddata[1]),
    .dbus_stall(stall[1]), .sram_addr(saddr[1]), .sram_data_i(sdi[1]), .sram_data_o(sdo[1]),
    .sram_data_oe(soe[1]), .sram_ce_n(ce_n[1]), .sram_oe_n(oe_n[1]), .sram_we_n(we_n[1]),
    .sram_lb_n(lb_n[1]), .sram_ub_n(ub_n[1]));

  function automatic logic [15:0] mem_rd(int k, logic [19:0] a);
    if (written[k][a[7:0]]) return mem[k][a[7:0]];
    return a == 20'h20 ? 16'h5678 : a == 20'h21 ? 16'h1234 : 16'h0000;
  endfunction
  assign sdi[0] = (!ce_n[0] && !oe_n[0]) ? mem_rd(0, saddr[0]) : 16'hFFFF;
  assign sdi[1] = (!ce_n[1] && !oe_n[1]) ? mem_rd(1, saddr[1]) : 16'hFFFF;

  always @(posedge clk)
    for (int k = 0; k < 2; k++)
      if (!ce_n[k] && !we_n[k]) begin
        if (!lb_n[k]) mem[k][saddr[k][7:0]][7:0] <= soe[k] ? sdo[k][7:0] : 8'h00;
        if (!ub_n[k]) mem[k][saddr[k][7:0]][15:8] <= soe[k] ? sdo[k][15:8] : 8'h00;
        written[k][saddr[k][7:0]] <= 1'b1;
      end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run(input int s, input bit w, input bit both, input logic [31:0] a,
                     input logic [3:0] b, input logic [31:0] wd, output int n_st,
                     output int n_oe, output int n_we, output bit ce_seen,
                     output logic [19:0] fa, output logic [19:0] la, output bit viol,
                     output bit lbw, output bit ubw, output logic [31:0] rdv);
    @(negedge clk);
    addr[s] = a; be[s] = b; wrdata[s] = wd; wr[s] = w; rd[s] = !w || both;
    #1;
    n_st = 0; n_oe = 0; n_we = 0; ce_seen = 0; fa = '0; la = '0; viol = 0; lbw = 1; ubw = 1;
    for (int c = 0; c < 60; c++) begin
      if (!oe_n[s]) n_oe++;
      if (!we_n[s]) begin n_we++; lbw = lb_n[s]; ubw = ub_n[s]; end
      if (!ce_n[s]) begin if (!ce_seen) fa = saddr[s]; ce_seen = 1; la = saddr[s]; end
      if (!oe_n[s] && soe[s]) viol = 1;
      if (!stall[s]) break;
      n_st++;
      @(negedge clk); #1;
    end
    if (stall[s]) chk("stall_timeout", 32'(stall[s]), 32'd0);
    rdv = rddata[s];
    rd[s] = 0; wr[s] = 0;
  endtask

  typedef struct {
    int s; bit w; bit both; logic [31:0] a; logic [3:0] be; logic [31:0] wd;
    logic [31:0] exp_rd; int exp_stall; int exp_strb;
  } vec_t;
  vec_t v[13];

  initial begin
    int n_st, n_oe, n_we;
    bit ce_seen, viol, lbw, ubw;
    logic [19:0] fa, la;
    logic [31:0] rdv;
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 0; addr[k] = 0; be[k] = 0; wrdata[k] = 0; rd[k] = 0; wr[k] = 0;
    end
    v[0]  = '{0, 0, 0, 32'h40, 4'hF, 32'h0,        32'h12345678, 3, 2};
    v[1]  = '{0, 1, 0, 32'h44, 4'hF, 32'hDEADBEEF, 32'h0,        5, 2};
    v[2]  = '{0, 0, 0, 32'h44, 4'hF, 32'h0,        32'hDEADBEEF, 3, 2};
    v[3]  = '{0, 1, 0, 32'h44, 4'h4, 32'h00AA0000, 32'h0,        3, 1};
    v[4]  = '{0, 0, 0, 32'h44, 4'hF, 32'h0,        32'hDEAABEEF, 3, 2};
    v[5]  = '{0, 0, 0, 32'h40, 4'h3, 32'h0,        32'h00005678, 2, 1};
    v[6]  = '{0, 0, 0, 32'h40, 4'h0, 32'h0,        32'h00000000, 1, 0};
    v[7]  = '{0, 0, 0, 32'h40, 4'h8, 32'h0,        32'h12000000, 2, 1};
    v[8]  = '{0, 1, 1, 32'h48, 4'hF, 32'h0BADF00D, 32'h0,        5, 2};
    v[9]  = '{0, 0, 0, 32'h48, 4'hF, 32'h0,        32'h0BADF00D, 3, 2};
    v[10] = '{1, 0, 0, 32'h40, 4'hF, 32'h0,        32'h12345678, 7, 6};
    v[11] = '{1, 0, 0, 32'h40, 4'hF, 32'h0,        32'h12345678, 7, 6};
    v[12] = '{1, 1, 0, 32'h44, 4'h3, 32'h0000CAFE, 32'h0,        5, 3};
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_rddata", rddata[k], 32'h0);
      chk("reset_strobes", {27'h0, ce_n[k], oe_n[k], we_n[k], lb_n[k], ub_n[k]}, 32'h1F);
      chk("reset_oe_addr", {11'h0, soe[k], saddr[k]}, 32'h0);
    end
    rst_n[0] = 1; rst_n[1] = 1;
    for (int i = 0; i < 13; i++) begin
      run(v[i].s, v[i].w, v[i].both, v[i].a, v[i].be, v[i].wd, n_st, n_oe, n_we, ce_seen,
          fa, la, viol, lbw, ubw, rdv);
      chk($sformatf("v%0d_stall", i), n_st, v[i].exp_stall);
      chk($sformatf("v%0d_strobe_cycles", i), v[i].w ? n_we : n_oe, v[i].exp_strb);
      chk($sformatf("v%0d_oe_overlap", i), 32'(viol), 32'd0);
      if (!v[i].w) chk($sformatf("v%0d_rddata", i), rdv, v[i].exp_rd);
      if (v[i].exp_strb == 0) chk($sformatf("v%0d_no_ce", i), 32'(ce_seen), 32'd0);
      if (i == 0) begin
        chk("v0_first_addr", 32'(fa), 32'h20);
        chk("v0_last_addr", 32'(la), 32'h21);
      end
      if (i == 3) begin
        chk("v3_lanes", {30'h0, lbw, ubw}, 32'h1);
        chk("v3_addr", 32'(fa), 32'h23);
      end
    end
    run(1, 0, 0, 32'h44, 4'hF, 32'h0, n_st, n_oe, n_we, ce_seen, fa, la, viol, lbw, ubw, rdv);
    chk("w3_readback", rdv, 32'h0000CAFE);
    chk("w3_readback_stall", n_st, 7);
    @(negedge clk);
    addr[0] = 32'h50; be[0] = 4'hF; wrdata[0] = 32'h11112222; wr[0] = 1;
    repeat (3) @(negedge clk);
    chk("mid_hi_we", 32'(we_n[0]), 32'd0);
    rst_n[0] = 0;
    #1;
    chk("async_strobes", {27'h0, ce_n[0], oe_n[0], we_n[0], lb_n[0], ub_n[0]}, 32'h1F);
    chk("async_data_oe", 32'(soe[0]), 32'd0);
    chk("async_rddata", rddata[0], 32'h0);
    wr[0] = 0;
    @(negedge clk);
    rst_n[0] = 1;
    run(0, 0, 0, 32'h40, 4'hF, 32'h0, n_st, n_oe, n_we, ce_seen, fa, la, viol, lbw, ubw, rdv);
    chk("post_reset_rddata", rdv, 32'h12345678);
    chk("post_reset_stall", n_st, 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dbus_sram_bridge.md
# dbus_sram_bridge

Data-bus responder for `naive_mips`: accepts the CPU's 32-bit `dbus_*` requests and executes them on an external 16-bit asynchronous SRAM (AS7C34098A class) as one or two halfword phases. While an access is in progress it holds the CPU with `dbus_stall`. It replaces the zero-latency behavioural RAM on the data bus and is the other end of the `dbus_*` interface the CPU drives.

## Interface

**Parameters**
- `ADDR_WIDTH`, default 20: SRAM halfword address width. Word index is `dbus_address[ADDR_WIDTH:2]`.
- `WAIT_CYCLES`, default 1: cycles of asserted `sram_oe_n`/`sram_we_n` per phase. Legal range is 1–15.

**Ports** (name, direction, width, meaning)
- `clk` input 1: single clock; everything is rising-edge.
- `rst_n` input 1: asynchronous active-low reset.
- `dbus_address` input 32: byte address; bits [1:0] are ignored.
- `dbus_byteenable` input 4: byte lanes; bit0 is [7:0].
- `dbus_read` input 1: read request.
- `dbus_write` input 1: write request.
- `dbus_wrdata` input 32: write data.
- `dbus_rddata` output 32: read data, registered.
- `dbus_stall` output 1: holds the CPU; all request inputs stay stable while it is high.
- `sram_addr` output ADDR_WIDTH: halfword address.
- `sram_data_i` input 16: SRAM data in.
- `sram_data_o` output 16: SRAM data out.
- `sram_data_oe` output 1: pad tri-state enable.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_lb_n`, `sram_ub_n` output 1 each: SRAM strobes, active low.

## Operation

**State machine:** IDLE, LO, HI, DONE.

**Requests**
- A request exists when `dbus_read | dbus_write`. If both are asserted, the write takes priority.
- `dbus_stall = req & (state != DONE)`. This is combinational, so the CPU stalls in the request cycle itself.

**IDLE**
- With a request: latch op, address, byteenable and wrdata; clear the data register.
- Next state:
  - LO if `be[1:0] != 0`;
  - else HI if `be[3:2] != 0`;
  - else DONE.

**Phase address and strobes**
- LO uses halfword address `{word,1'b0}` and lanes `be[1:0]`.
- HI uses halfword address `{word,1'b1}` and lanes `be[3:2]`.
- `sram_lb_n = ~be_lo`, `sram_ub_n = ~be_hi` for the active half.
- `sram_ce_n` is low throughout LO and HI.

**Reads**
- `sram_oe_n` is low for WAIT_CYCLES cycles.
- `sram_data_i` is captured on the last of those cycles:
  - into rddata[15:0] in LO;
  - into rddata[31:16] in HI.
- Only enabled bytes are written; other bytes read as 0.

**Writes**
- `sram_data_oe` is high and `sram_data_o` carries the phase's half of wrdata for the whole phase.
- `sram_we_n` is low for WAIT_CYCLES cycles, then high for one recovery cycle. Address and data are held during recovery.

**Phase sequencing**
- LO goes to HI if `be[3:2] != 0`, else to DONE.
- HI goes to DONE.
- A 4-bit counter times each phase.

**DONE**
- Lasts one cycle: `dbus_stall` is low and `dbus_rddata` is valid.
- Always returns to IDLE.
- A request present in the following cycle is a new access, even if the address is unchanged.

**Reset values** (also applied on reset mid-access)
- State is IDLE.
- `dbus_rddata` = 0.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_lb_n`, `sram_ub_n` = 1.
- `sram_data_oe` = 0, `sram_data_o` = 0, `sram_addr` = 0.
- A write interrupted by reset may leave a partially written word. No completion is signalled.

**Idle outputs:** all SRAM strobes are high and `sram_data_oe` = 0.

## Timing

- All SRAM outputs are registered; they change only at clock edges.
- Cycle 0 is the request cycle, in IDLE.
- Read phase length is WAIT_CYCLES; write phase length is WAIT_CYCLES+1.
- Stall cycles:
  - full-word read: 1 + 2·WAIT;
  - full-word write: 1 + 2·(WAIT+1);
  - single-half access: one phase fewer;
  - `be = 0`: 1 stall cycle, then DONE.
- With WAIT=1:
  - full-word read stalls 3 cycles and DONE is in cycle 3;
  - full-word write stalls 5 cycles and DONE is in cycle 5.
- Never drive `sram_oe_n` low and `sram_data_oe` high in the same cycle.
- Insert a one-cycle gap between `sram_data_oe` deasserting and any `sram_oe_n` assertion. The IDLE/DONE cycles provide this gap.

## Test plan

1. **Full-word read, WAIT=1.** SRAM model holds 0x5678 @0x20 and 0x1234 @0x21. Read `dbus_address` 0x40, be=1111 → stall high for cycles 0–2; `sram_addr` = 0x20 then 0x21; in cycle 3 stall is low and `dbus_rddata` = 0x12345678.
2. **Full-word write.** Write 0xDEADBEEF to 0x44, be=1111 → 0xBEEF written @0x22 and 0xDEAD @0x23; `sram_we_n` low 1 cycle per phase; stall for 5 cycles. A read-back returns 0xDEADBEEF.
3. **Byte write.** Write lane be=0100 with wrdata 0x00AA0000 to 0x44 → HI phase only, `sram_lb_n` = 0, `sram_ub_n` = 1; stall for 3 cycles. The word then reads 0xDEAABEEF.
4. **Partial read and empty enable.**
   - Read be=0011 at 0x40 → LO phase only; rddata = 0x00005678; stall for 2 cycles.
   - be=0000 read → stall for 1 cycle; rddata = 0; no SRAM strobe activity.
5. **WAIT_CYCLES=3.** Full-word read → `sram_oe_n` low for 3 cycles per phase; stall for 7 cycles. Back-to-back reads at the same address each incur a full access.
6. **Reset mid-access.** Assert `rst_n` low during the HI phase of a write → all strobes high and `sram_data_oe` = 0 immediately (asynchronously); `dbus_rddata` = 0. After release, a new read completes normally.
